// File: rtl/matrix_result_streamer.sv
// matrix_result_streamer: captures a DIMxDIM result matrix and streams it row-major over valid/ready,
// reporting the diagonal trace and counting loads dropped while busy.
module matrix_result_streamer #(
  parameter int ELEM_W = 8,
  parameter int DIM = 3,
  localparam int MAT_W = DIM*DIM*ELEM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [MAT_W-1:0]  matrix_in,
  output logic [ELEM_W-1:0] out_data,
  output logic [1:0]        out_row,
  output logic [1:0]        out_col,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic [ELEM_W+1:0] trace,
  output logic [7:0]        drop_count
);
  localparam int TW = ELEM_W+2;
  localparam logic [1:0] LAST = 2'(DIM-1);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state_q, state_d;
  logic [1:0] row_q, row_d, col_q, col_d;
  logic [MAT_W-1:0] shadow_q, shadow_d;
  logic [TW-1:0] trace_q, trace_d, diag;
  logic [7:0] drop_q, drop_d;
  logic xfer, at_last, capture;
  always_comb begin
    diag = '0;
    for (int i = 0; i < DIM; i++) diag = diag + TW'(matrix_in[(i*DIM+i)*ELEM_W +: ELEM_W]);
  end
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    shadow_d = shadow_q;
    trace_d = trace_q;
    drop_d = drop_q;
    xfer = state_q == STREAM && out_ready;
    at_last = row_q == LAST && col_q == LAST;
    capture = load && (state_q == IDLE || (xfer && at_last));
    if (xfer) begin
      col_d = col_q == LAST ? 2'd0 : col_q + 2'd1;
      row_d = at_last ? 2'd0 : col_q == LAST ? row_q + 2'd1 : row_q;
      state_d = at_last ? IDLE : STREAM;
    end
    // A load landing on the final accepted beat chains the next matrix with no bubble.
    if (capture) begin
      shadow_d = matrix_in;
      trace_d = diag;
      row_d = '0;
      col_d = '0;
      state_d = STREAM;
    end else if (load && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      row_q <= '0;
      col_q <= '0;
      shadow_q <= '0;
      trace_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      shadow_q <= shadow_d;
      trace_q <= trace_d;
      drop_q <= drop_d;
    end
  end
  assign out_valid = state_q == STREAM;
  assign busy = state_q == STREAM;
  assign out_last = out_valid && at_last;
  assign out_data = shadow_q[(int'(row_q)*DIM + int'(col_q))*ELEM_W +: ELEM_W];
  assign out_row = row_q;
  assign out_col = col_q;
  assign trace = trace_q;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_matrix_result_streamer.sv
// tb_matrix_result_streamer: table vectors plus a queue-based beat model under directed and random stimulus.
module tb_matrix_result_streamer;
  logic clk = 0, rst = 0, load = 0, out_ready = 0;
  logic [71:0] matrix_in = '0;
  logic [7:0] out_data, drop_count;
  logic [1:0] out_row, out_col;
  logic out_valid, out_last, busy;
  logic [9:0] trace;
  int tests = 0, fails = 0, xfers = 0;

  matrix_result_streamer dut (
    .clk(clk), .rst(rst), .load(load), .matrix_in(matrix_in), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .trace(trace), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] d; logic [1:0] r; logic [1:0] c; } beat_t;
  beat_t q[$];
  int m_trace = 0, m_drop = 0;

  typedef struct { logic ld; logic rdy; logic ev; logic [7:0] ed; logic [1:0] er; logic [1:0] ec; logic el; } vec_t;
  vec_t vt[11];

  task automatic chk(input string n, input int a, input int e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  function automatic logic [7:0] el(input logic [71:0] m, input int r, input int c);
    return m[(r*3+c)*8 +: 8];
  endfunction

  function automatic int trace_of(input logic [71:0] m);
    return int'(el(m,0,0)) + int'(el(m,1,1)) + int'(el(m,2,2));
  endfunction

  function automatic logic [71:0] rand_mat();
    logic [71:0] m;
    for (int k = 0; k < 9; k++) m[k*8 +: 8] = 8'($urandom);
    return m;
  endfunction

  // Called at a negedge: check outputs against the model, apply inputs, advance model on the edge.
  task automatic step(input logic ld, input logic [71:0] mat, input logic rdy);
    bit idle, fin;
    idle = q.size() == 0;
    chk("valid", int'(out_valid), int'(!idle));
    chk("busy", int'(busy), int'(!idle));
    chk("trace", int'(trace), m_trace);
    chk("drop", int'(drop_count), m_drop);
    if (!idle) begin
      chk("data", int'(out_data), int'(q[0].d));
      chk("row", int'(out_row), int'(q[0].r));
      chk("col", int'(out_col), int'(q[0].c));
      chk("last", int'(out_last), int'(q.size() == 1));
    end
    load = ld;
    matrix_in = mat;
    out_ready = rdy;
    @(posedge clk);
    fin = !idle && rdy && q.size() == 1;
    if (!idle && rdy) begin
      void'(q.pop_front());
      xfers++;
    end
    if (ld) begin
      if (idle || fin) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) q.push_back({el(mat, r, c), 2'(r), 2'(c)});
        m_trace = trace_of(mat);
      end else if (m_drop < 255) m_drop++;
    end
    @(negedge clk);
    load = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 40) begin
      step(0, rand_mat(), 1);
      n++;
    end
    chk("drain_idle", int'(busy), 0);
  endtask

  logic [71:0] a, b, c, m;

  initial begin
    for (int k = 0; k < 9; k++) a[k*8 +: 8] = 8'(k+1);
    vt[0] = '{1, 1, 1, 8'd1, 2'd0, 2'd0, 0};
    for (int k = 1; k < 9; k++) vt[k] = '{0, 1, 1, 8'(k+1), 2'(k/3), 2'(k%3), k == 8};
    vt[9] = '{0, 1, 0, 0, 0, 0, 0};
    vt[10] = '{0, 0, 0, 0, 0, 0, 0};

    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_trace", int'(trace), 0);
    chk("rst_drop", int'(drop_count), 0);
    chk("rst_last", int'(out_last), 0);

    for (int i = 0; i < 11; i++) begin
      load = vt[i].ld;
      matrix_in = a;
      out_ready = vt[i].rdy;
      @(posedge clk);
      @(negedge clk);
      chk("tbl_valid", int'(out_valid), int'(vt[i].ev));
      chk("tbl_busy", int'(busy), int'(vt[i].ev));
      if (vt[i].ev) begin
        chk("tbl_data", int'(out_data), int'(vt[i].ed));
        chk("tbl_row", int'(out_row), int'(vt[i].er));
        chk("tbl_col", int'(out_col), int'(vt[i].ec));
        chk("tbl_last", int'(out_last), int'(vt[i].el));
      end
    end
    chk("tbl_trace", int'(trace), 15);
    m_trace = 15;

    xfers = 0;
    step(1, a, 1);
    for (int i = 0; i < 40 && q.size() > 0; i++) step(0, rand_mat(), (i % 3) == 2);
    chk("bp_xfers", xfers, 9);
    chk("bp_idle", int'(busy), 0);

    b = rand_mat();
    c = rand_mat();
    step(1, a, 1);
    for (int i = 1; i <= 9; i++) step(i == 3 || i == 9, i == 3 ? c : b, 1);
    chk("b2b_drop", int'(drop_count), 1);
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_data", int'(out_data), int'(el(b, 0, 0)));
    chk("b2b_trace", int'(trace), trace_of(b));
    drain();

    step(1, a, 0);
    for (int i = 0; i < 300; i++) step(1, rand_mat(), 0);
    chk("sat_drop", int'(drop_count), 255);
    drain();

    m = '1;
    m[1*8 +: 8] = 8'h00;
    m[5*8 +: 8] = 8'h3C;
    step(1, m, 1);
    chk("max_trace", int'(trace), 765);
    drain();

    step(1, a, 1);
    repeat (3) step(0, rand_mat(), 1);
    chk("pre_rst_data", int'(out_data), 4);
    #2 rst = 0;
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_drop", int'(drop_count), 0);
    chk("arst_trace", int'(trace), 0);
    q.delete();
    m_trace = 0;
    m_drop = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);

    for (int i = 0; i < 2000; i++) step(($urandom % 4) == 0, rand_mat(), 1'($urandom % 2));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
